// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM link (transmit mux and receive demux).
package tdm_pkg;
  localparam int NCH    = 4;
  localparam int SLOT_W = 2;
  localparam int DEF_W  = 8;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// 2-bit TDM slot counter. Clear and increment together restart the count at slot 1,
// which is how a frame-sync word re-seeds alignment in the same edge it is accepted.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [SLOT_W-1:0] o_slot
);

  logic [SLOT_W-1:0] r_slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
    end else if (i_clr) begin
      r_slot <= i_inc ? SLOT_W'(1) : '0;
    end else if (i_inc) begin
      r_slot <= r_slot + 1'b1;
    end
  end

  assign o_slot = r_slot;

endmodule

// File: rtl/tdm_demux4_rx.sv
// Receive side of the 4-channel TDM link: aligns to frame_sync, collects slot words
// into shadow registers and publishes all four channels together once per frame.
module tdm_demux4_rx
  import tdm_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W-1:0]      din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [W-1:0]      ch0,
  output logic [W-1:0]      ch1,
  output logic [W-1:0]      ch2,
  output logic [W-1:0]      ch3,
  output logic              frame_valid,
  output logic              locked,
  output logic              sync_err,
  output logic [SLOT_W-1:0] slot
);

  state_t            r_state;
  logic [W-1:0]      r_shadow [NCH-1];
  logic [W-1:0]      r_ch     [NCH];
  logic              r_frame_valid;
  logic              r_sync_err;

  logic [SLOT_W-1:0] w_slot;
  logic              w_clr;
  logic              w_inc;
  logic              w_err;
  logic              w_pub;
  logic              w_st0;
  logic              w_sts;
  state_t            w_nstate;

  tdm_slot_ctr u_slot_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_slot (w_slot)
  );

  always_comb begin
    w_clr    = 1'b0;
    w_inc    = 1'b0;
    w_err    = 1'b0;
    w_pub    = 1'b0;
    w_st0    = 1'b0;
    w_sts    = 1'b0;
    w_nstate = r_state;
    if (din_valid) begin
      if (r_state == HUNT) begin
        if (frame_sync) begin
          w_clr    = 1'b1;
          w_inc    = 1'b1;
          w_st0    = 1'b1;
          w_nstate = LOCKED;
        end
      end else if (w_slot == '0) begin
        if (frame_sync) begin
          w_inc = 1'b1;
          w_st0 = 1'b1;
        end else begin
          w_err    = 1'b1;
          w_clr    = 1'b1;
          w_nstate = HUNT;
        end
      end else if (frame_sync) begin
        // Early sync: drop the partial frame and restart it with this word as slot 0.
        w_err = 1'b1;
        w_clr = 1'b1;
        w_inc = 1'b1;
        w_st0 = 1'b1;
      end else begin
        w_inc = 1'b1;
        w_sts = 1'b1;
        w_pub = (w_slot == SLOT_W'(NCH-1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= HUNT;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      for (int i = 0; i < NCH-1; i++) r_shadow[i] <= '0;
      for (int i = 0; i < NCH; i++)   r_ch[i]     <= '0;
    end else begin
      r_state       <= w_nstate;
      r_frame_valid <= w_pub;
      r_sync_err    <= w_err;
      if (w_st0) begin
        r_shadow[0] <= din;
      end
      if (w_sts && !w_pub) begin
        r_shadow[w_slot] <= din;
      end
      // The last slot goes straight to ch3 so the whole frame lands on one edge.
      if (w_pub) begin
        for (int i = 0; i < NCH-1; i++) r_ch[i] <= r_shadow[i];
        r_ch[NCH-1] <= din;
      end
    end
  end

  assign ch0         = r_ch[0];
  assign ch1         = r_ch[1];
  assign ch2         = r_ch[2];
  assign ch3         = r_ch[3];
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;
  assign locked      = (r_state == LOCKED);
  assign slot        = w_slot;

endmodule

// File: tb/tb_tdm_demux4_rx.sv
// Directed table-driven bench for tdm_demux4_rx with a hand-written async-reset sequence.
module tb_tdm_demux4_rx;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] ch0, ch1, ch2, ch3;
  logic       frame_valid;
  logic       locked;
  logic       sync_err;
  logic [1:0] slot;

  int n_tests;
  int n_fail;

  typedef struct {
    logic        rst_n;
    logic        dv;
    logic        fs;
    logic [7:0]  din;
    logic [36:0] exp;
  } vec_t;

  vec_t vecs[$];

  tdm_demux4_rx #(.W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .ch0         (ch0),
    .ch1         (ch1),
    .ch2         (ch2),
    .ch3         (ch3),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err),
    .slot        (slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [36:0] outs();
    return {ch0, ch1, ch2, ch3, frame_valid, locked, sync_err, slot};
  endfunction

  task automatic add(input logic r, input logic dv, input logic fs, input logic [7:0] d,
                     input logic [31:0] chs, input logic fv, input logic lk,
                     input logic se, input logic [1:0] sl);
    vec_t v;
    v.rst_n = r;
    v.dv    = dv;
    v.fs    = fs;
    v.din   = d;
    v.exp   = {chs, fv, lk, se, sl};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [36:0] got, input logic [36:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got ch=%h fv/lk/se=%b slot=%0d, expected ch=%h fv/lk/se=%b slot=%0d",
               name, got[36:5], got[4:2], got[1:0], exp[36:5], exp[4:2], exp[1:0]);
    end
  endtask

  task automatic run_vecs(input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      @(negedge clk);
      rst_n      = vecs[i].rst_n;
      din_valid  = vecs[i].dv;
      frame_sync = vecs[i].fs;
      din        = vecs[i].din;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end
  endtask

  initial begin
    int part_a;
    logic [31:0] c;
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    din        = 8'h00;

    // reset, aligned frame
    add(0,0,0,8'h00, 32'h0, 0,0,0,0);
    add(1,1,1,8'h11, 32'h0, 0,1,0,1);
    add(1,1,0,8'h22, 32'h0, 0,1,0,2);
    add(1,1,0,8'h33, 32'h0, 0,1,0,3);
    add(1,1,0,8'h44, 32'h11223344, 1,1,0,0);
    add(1,0,0,8'h00, 32'h11223344, 0,1,0,0);
    // pre-sync garbage after a reset
    add(0,0,0,8'h00, 32'h0, 0,0,0,0);
    add(1,1,0,8'hAA, 32'h0, 0,0,0,0);
    add(1,1,0,8'hAA, 32'h0, 0,0,0,0);
    add(1,1,0,8'hAA, 32'h0, 0,0,0,0);
    add(1,1,1,8'h01, 32'h0, 0,1,0,1);
    add(1,1,0,8'h02, 32'h0, 0,1,0,2);
    add(1,1,0,8'h03, 32'h0, 0,1,0,3);
    add(1,1,0,8'h04, 32'h01020304, 1,1,0,0);
    // gaps, including frame_sync without din_valid
    c = 32'h01020304;
    add(1,1,1,8'h05, c, 0,1,0,1);
    add(1,0,0,8'h00, c, 0,1,0,1);
    add(1,0,1,8'hEE, c, 0,1,0,1);
    add(1,1,0,8'h06, c, 0,1,0,2);
    add(1,0,1,8'hEE, c, 0,1,0,2);
    add(1,0,0,8'h00, c, 0,1,0,2);
    add(1,1,0,8'h07, c, 0,1,0,3);
    add(1,0,0,8'h00, c, 0,1,0,3);
    add(1,0,0,8'h00, c, 0,1,0,3);
    add(1,1,0,8'h08, 32'h05060708, 1,1,0,0);
    add(1,0,0,8'h00, 32'h05060708, 0,1,0,0);
    // early sync at slot 2
    c = 32'h05060708;
    add(1,1,1,8'h10, c, 0,1,0,1);
    add(1,1,0,8'h20, c, 0,1,0,2);
    add(1,1,1,8'h50, c, 0,1,1,1);
    add(1,1,0,8'h60, c, 0,1,0,2);
    add(1,1,0,8'h70, c, 0,1,0,3);
    add(1,1,0,8'h80, 32'h50607080, 1,1,0,0);
    // early sync at slot 3 suppresses the publish
    c = 32'h50607080;
    add(1,1,1,8'h1A, c, 0,1,0,1);
    add(1,1,0,8'h1B, c, 0,1,0,2);
    add(1,1,0,8'h1C, c, 0,1,0,3);
    add(1,1,1,8'h1D, c, 0,1,1,1);
    add(1,1,0,8'h2B, c, 0,1,0,2);
    add(1,1,0,8'h2C, c, 0,1,0,3);
    add(1,1,0,8'h2D, 32'h1D2B2C2D, 1,1,0,0);
    // missing sync on the second frame's slot 0, then relock
    c = 32'h1D2B2C2D;
    add(1,1,1,8'hA1, c, 0,1,0,1);
    add(1,1,0,8'hA2, c, 0,1,0,2);
    add(1,1,0,8'hA3, c, 0,1,0,3);
    add(1,1,0,8'hA4, 32'hA1A2A3A4, 1,1,0,0);
    c = 32'hA1A2A3A4;
    add(1,1,0,8'h99, c, 0,0,1,0);
    add(1,1,0,8'h55, c, 0,0,0,0);
    add(1,1,1,8'hB1, c, 0,1,0,1);
    add(1,1,0,8'hB2, c, 0,1,0,2);
    add(1,1,0,8'hB3, c, 0,1,0,3);
    add(1,1,0,8'hB4, 32'hB1B2B3B4, 1,1,0,0);
    // partial frame before the mid-frame reset
    c = 32'hB1B2B3B4;
    add(1,1,1,8'hC1, c, 0,1,0,1);
    add(1,1,0,8'hC2, c, 0,1,0,2);
    add(1,1,0,8'hC3, c, 0,1,0,3);
    part_a = vecs.size();
    // after reset: the tail word is discarded, then a full synced frame
    add(0,0,0,8'h00, 32'h0, 0,0,0,0);
    add(1,1,0,8'hC4, 32'h0, 0,0,0,0);
    add(1,0,0,8'h00, 32'h0, 0,0,0,0);
    add(1,1,1,8'hD1, 32'h0, 0,1,0,1);
    add(1,1,0,8'hD2, 32'h0, 0,1,0,2);
    add(1,1,0,8'hD3, 32'h0, 0,1,0,3);
    add(1,1,0,8'hD4, 32'hD1D2D3D4, 1,1,0,0);
    add(1,0,0,8'h00, 32'hD1D2D3D4, 0,1,0,0);

    run_vecs(0, part_a);

    // Reset mid-cycle, no clock edge: outputs must clear at once.
    #1;
    din_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("async_reset", outs(), 37'h0);

    run_vecs(part_a, vecs.size());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
